// File: rtl/reg_univ.sv
`default_nettype none
// ============================================================================
// Module   : reg_univ
// Purpose  : Universal register with load, shift, rotate, increment/decrement,
//            serial out and a wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module reg_univ #(
   parameter int               WIDTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             eck,
   input  logic             er,
   input  logic             es,
   input  logic             eena,
   input  logic [2:0]       emode,
   input  logic [WIDTH-1:0] ed,
   input  logic             esi,
   output logic [WIDTH-1:0] sq,
   output logic             sso,
   output logic             scarry,
   output logic             szero
);

   localparam logic [2:0] c_MODE_HOLD = 3'b000;
   localparam logic [2:0] c_MODE_LOAD = 3'b001;
   localparam logic [2:0] c_MODE_SHL  = 3'b010;
   localparam logic [2:0] c_MODE_SHR  = 3'b011;
   localparam logic [2:0] c_MODE_ROL  = 3'b100;
   localparam logic [2:0] c_MODE_ROR  = 3'b101;
   localparam logic [2:0] c_MODE_INC  = 3'b110;
   localparam logic [2:0] c_MODE_DEC  = 3'b111;

   localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] sq_q, sq_d;
   logic             sso_q, sso_d;
   logic             scarry_q, scarry_d;

   // Set overrides every mode, so it also suppresses shift-out and wrap reporting.
   always_comb begin
      sq_d     = sq_q;
      sso_d    = sso_q;
      scarry_d = 1'b0;
      if (es) begin
         sq_d  = '1;
         sso_d = 1'b0;
      end else if (eena) begin
         case (emode)
            c_MODE_HOLD: sq_d = sq_q;
            c_MODE_LOAD: sq_d = ed;
            c_MODE_SHL: begin
               sq_d  = {sq_q[WIDTH-2:0], esi};
               sso_d = sq_q[WIDTH-1];
            end
            c_MODE_SHR: begin
               sq_d  = {esi, sq_q[WIDTH-1:1]};
               sso_d = sq_q[0];
            end
            c_MODE_ROL: begin
               sq_d  = {sq_q[WIDTH-2:0], sq_q[WIDTH-1]};
               sso_d = sq_q[WIDTH-1];
            end
            c_MODE_ROR: begin
               sq_d  = {sq_q[0], sq_q[WIDTH-1:1]};
               sso_d = sq_q[0];
            end
            c_MODE_INC: begin
               sq_d     = sq_q + c_ONE;
               scarry_d = (sq_q == '1);
            end
            c_MODE_DEC: begin
               sq_d     = sq_q - c_ONE;
               scarry_d = (sq_q == '0);
            end
            default: sq_d = sq_q;
         endcase
      end
   end

   always_ff @(posedge eck) begin
      if (er) begin
         sq_q     <= RST_VAL;
         sso_q    <= 1'b0;
         scarry_q <= 1'b0;
      end else begin
         sq_q     <= sq_d;
         sso_q    <= sso_d;
         scarry_q <= scarry_d;
      end
   end

   assign sq     = sq_q;
   assign sso    = sso_q;
   assign scarry = scarry_q;
   assign szero  = (sq_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_reg_univ.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_univ
// Purpose  : Self-checking bench for reg_univ at WIDTH=3 and WIDTH=8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_univ;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       r3, s3, en3, si3;
   logic [2:0] md3;
   logic [2:0] d3;
   logic [2:0] sq3;
   logic       so3, c3, z3;

   logic       r8, s8, en8, si8;
   logic [2:0] md8;
   logic [7:0] d8;
   logic [7:0] sq8;
   logic       so8, c8, z8;

   int n_tests = 0;
   int n_fail  = 0;

   int m3_q = 0, m3_so = 0, m3_c = 0;
   int m8_q = 0, m8_so = 0, m8_c = 0;

   reg_univ #(.WIDTH(3), .RST_VAL(3'b000)) u_dut3 (
      .eck(clk), .er(r3), .es(s3), .eena(en3), .emode(md3), .ed(d3), .esi(si3),
      .sq(sq3), .sso(so3), .scarry(c3), .szero(z3)
   );

   reg_univ #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
      .eck(clk), .er(r8), .es(s8), .eena(en8), .emode(md8), .ed(d8), .esi(si8),
      .sq(sq8), .sso(so8), .scarry(c8), .szero(z8)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Arithmetic reference: register viewed as an integer modulo 2^w.
   task automatic model(input int w, input int rst, input bit r, input bit s, input bit en,
                        input int mode, input int d, input int si,
                        inout int q, inout int so, inout int c);
      int m, top, low;
      m   = 1 << w;
      top = q / (m / 2);
      low = q % 2;
      c   = 0;
      if (r) begin
         q = rst; so = 0;
      end else if (s) begin
         q = m - 1; so = 0;
      end else if (en) begin
         case (mode)
            1: q = d;
            2: begin so = top; q = (q * 2 + si) % m; end
            3: begin so = low; q = q / 2 + si * (m / 2); end
            4: begin so = top; q = (q * 2 + top) % m; end
            5: begin so = low; q = q / 2 + low * (m / 2); end
            6: begin c = (q == m - 1) ? 1 : 0; q = (q + 1) % m; end
            7: begin c = (q == 0) ? 1 : 0; q = (q + m - 1) % m; end
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      model(3, 0, r3, s3, en3, int'(md3), int'(d3), int'(si3), m3_q, m3_so, m3_c);
      model(8, 'hA5, r8, s8, en8, int'(md8), int'(d8), int'(si8), m8_q, m8_so, m8_c);
      @(posedge clk);
      #1;
      chk("w3_sq", 32'(sq3), m3_q);
      chk("w3_sso", 32'(so3), m3_so);
      chk("w3_scarry", 32'(c3), m3_c);
      chk("w3_szero", 32'(z3), (m3_q == 0) ? 1 : 0);
      chk("w8_sq", 32'(sq8), m8_q);
      chk("w8_sso", 32'(so8), m8_so);
      chk("w8_scarry", 32'(c8), m8_c);
      chk("w8_szero", 32'(z8), (m8_q == 0) ? 1 : 0);
   endtask

   task automatic op3(input bit r, input bit s, input bit en, input logic [2:0] md,
                      input logic [2:0] d, input bit si);
      r3 = r; s3 = s; en3 = en; md3 = md; d3 = d; si3 = si;
      r8 = 1'b0; s8 = 1'b0; en8 = 1'b0; md8 = 3'b000; d8 = 8'h00; si8 = 1'b0;
      tick();
   endtask

   task automatic op8(input bit r, input bit s, input bit en, input logic [2:0] md,
                      input logic [7:0] d);
      r8 = r; s8 = s; en8 = en; md8 = md; d8 = d; si8 = 1'b0;
      r3 = 1'b0; s3 = 1'b0; en3 = 1'b0; md3 = 3'b000; d3 = 3'b000; si3 = 1'b0;
      tick();
   endtask

   initial begin
      r3 = 1'b1; s3 = 1'b1; en3 = 1'b1; md3 = 3'b001; d3 = 3'b101; si3 = 1'b0;
      r8 = 1'b1; s8 = 1'b0; en8 = 1'b0; md8 = 3'b000; d8 = 8'h00; si8 = 1'b0;
      tick();
      chk("tp_rst_sq", 32'(sq3), 0);
      chk("tp_rst_szero", 32'(z3), 1);
      chk("tp_rst8_sq", 32'(sq8), 'hA5);

      op3(0, 0, 1, 3'b001, 3'b101, 0);
      op3(0, 0, 1, 3'b010, 3'b000, 1);
      chk("tp_shl_sq", 32'(sq3), 3'b011);
      chk("tp_shl_sso", 32'(so3), 1);
      op3(0, 0, 1, 3'b011, 3'b000, 0);
      chk("tp_shr_sq", 32'(sq3), 3'b001);
      chk("tp_shr_sso", 32'(so3), 1);

      op3(0, 0, 1, 3'b001, 3'b110, 0);
      op3(0, 0, 1, 3'b100, 3'b000, 0);
      chk("tp_rol1", 32'({sq3, so3}), 4'b1011);
      op3(0, 0, 1, 3'b100, 3'b000, 0);
      chk("tp_rol2", 32'({sq3, so3}), 4'b0111);
      op3(0, 0, 1, 3'b100, 3'b000, 0);
      chk("tp_rol3", 32'({sq3, so3}), 4'b1100);

      op3(0, 0, 1, 3'b001, 3'b110, 0);
      op3(0, 0, 1, 3'b110, 3'b000, 0);
      chk("tp_inc1", 32'({sq3, c3}), 4'b1110);
      op3(0, 0, 1, 3'b110, 3'b000, 0);
      chk("tp_inc_wrap", 32'({sq3, c3, z3}), 5'b00011);
      op3(0, 0, 1, 3'b111, 3'b000, 0);
      chk("tp_dec_wrap", 32'({sq3, c3}), 4'b1111);

      op3(0, 0, 1, 3'b001, 3'b010, 0);
      for (int i = 0; i < 3; i++) begin
         op3(0, 0, 0, 3'b110, 3'b000, 0);
         chk("tp_hold", 32'({sq3, c3}), 4'b0100);
      end
      op3(0, 1, 1, 3'b110, 3'b000, 0);
      chk("tp_set", 32'({sq3, c3}), 4'b1110);

      op8(0, 0, 1, 3'b001, 8'hFE);
      op8(0, 0, 1, 3'b110, 8'h00);
      chk("tp8_ff", 32'({sq8, c8}), {8'hFF, 1'b0});
      op8(0, 0, 1, 3'b110, 8'h00);
      chk("tp8_wrap", 32'({sq8, c8}), {8'h00, 1'b1});
      op8(0, 0, 1, 3'b001, 8'hFF);
      op8(1, 0, 1, 3'b110, 8'h00);
      chk("tp8_rst_mid", 32'({sq8, c8}), {8'hA5, 1'b0});

      for (int i = 0; i < 3000; i++) begin
         r3  = ($urandom % 20) == 0;  s3 = ($urandom % 20) == 0;
         en3 = ($urandom % 4) != 0;   md3 = 3'($urandom);
         d3  = 3'($urandom);          si3 = 1'($urandom);
         r8  = ($urandom % 20) == 0;  s8 = ($urandom % 20) == 0;
         en8 = ($urandom % 4) != 0;   md8 = 3'($urandom);
         d8  = 8'($urandom);          si8 = 1'($urandom);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
